ir_key_decoder: RTL
===================

Name: ir_key_decoder

Overview:
- Sits directly downstream of the NEC IR receiver. Consumes its raw 32-bit frame strobe and its repeat-code strobe.
- Checks each frame's integrity and optionally filters it by address.
- Tracks held-key state across repeat codes and emits single-cycle key events, including auto-repeat events, for the display/control logic.
- Counts integrity errors for debug display on the seven-segment digits.

Parameters:
P_HOLD_TO, 6000000, clk cycles with no repeat/frame before a held key is released (120 ms at 50 MHz)
P_RPT_START, 4, number of repeat codes that must be received before auto-repeat events begin
P_ADDR_EN, 0, 1 = drop frames whose address differs from P_ADDR
P_ADDR, 8'h00, accepted address when P_ADDR_EN = 1
P_EXT_ADDR, 0, 1 = NEC extended addressing: bits [31:16] form a 16-bit address with no inversion check

Ports:
clk  input  1  system clock (50 MHz)
rst_n  input  1  asynchronous active-low reset
i_frame  input  32  NEC frame: [31:24] addr, [23:16] ~addr, [15:8] cmd, [7:0] ~cmd
i_frame_vld  input  1  1-cycle pulse; i_frame is valid in that cycle
i_rpt_vld  input  1  1-cycle pulse on a received NEC repeat code
o_addr  output  16  address of the last accepted key; upper 8 bits are 0 unless P_EXT_ADDR
o_cmd  output  8  command of the last accepted key
o_key_vld  output  1  1-cycle key event pulse
o_key_rpt  output  1  qualifies o_key_vld: 0 = new press, 1 = auto-repeat
o_key_held  output  1  level; high while the key is held
o_release  output  1  1-cycle pulse when a held key times out
o_err  output  1  1-cycle pulse on an integrity failure
o_err_cnt  output  8  saturating integrity-error counter

Behaviour:
- Reset (asynchronous, active-low) clears everything:
  - state = IDLE.
  - All outputs = 0; o_addr = 0, o_cmd = 0, o_err_cnt = 0.
  - Hold timer = 0; repeat counter = 0.
- Integrity check is combinational on i_frame:
  - cmd_ok = (i_frame[15:8] == ~i_frame[7:0]).
  - addr_ok = (i_frame[31:24] == ~i_frame[23:16]), or forced to 1 when P_EXT_ADDR = 1.
  - Frame is good when cmd_ok && addr_ok.
- Address filter: when P_ADDR_EN = 1 and P_EXT_ADDR = 0, a good frame with i_frame[31:24] != P_ADDR is dropped silently.
  - Dropped means: no event, no error, no state change.
- All outputs are registered. Every response appears exactly one clk cycle after the input pulse is sampled.
- State machine, IDLE:
  - Good, unfiltered frame: latch o_addr/o_cmd, pulse o_key_vld with o_key_rpt = 0, set o_key_held = 1, load timer = P_HOLD_TO, clear repeat counter, go to HELD.
  - Bad frame: pulse o_err, o_err_cnt += 1, stay in IDLE.
  - i_rpt_vld (orphan repeat): ignored.
- State machine, HELD:
  - Timer decrements by 1 every cycle.
  - i_rpt_vld: reload timer = P_HOLD_TO; repeat counter += 1, saturating at 255.
    - If the post-increment count is >= P_RPT_START: pulse o_key_vld with o_key_rpt = 1; o_addr/o_cmd unchanged.
  - Good, unfiltered frame: treated as a new press. Latch the new addr/cmd, pulse o_key_vld with o_key_rpt = 0, reload the timer, clear the repeat counter, stay in HELD.
  - Bad frame: pulse o_err, o_err_cnt += 1, clear o_key_held, pulse o_release, go to IDLE.
  - Timer reaches 0: clear o_key_held, pulse o_release, go to IDLE. o_addr/o_cmd retain their last values.
- Simultaneous events:
  - i_frame_vld and i_rpt_vld in the same cycle: the frame is processed and the repeat is discarded.
  - i_rpt_vld in the same cycle the timer would reach 0: the repeat wins; the timer reloads and there is no release.
- o_err_cnt saturates at 8'hFF. Errors at saturation still pulse o_err.
- o_key_rpt is 0 in every cycle where o_key_vld = 0.
- Reset asserted mid-HELD: immediate return to IDLE. No o_release pulse is generated.
- Hold timer width is $clog2(P_HOLD_TO+1); it must not wrap below 0.

Test Plan:
- Reset, then i_frame = 32'h00FF_45BA pulsed -> next cycle: o_key_vld = 1, o_key_rpt = 0, o_addr = 16'h0000, o_cmd = 8'h45, o_key_held = 1; o_release = 1 exactly P_HOLD_TO cycles later, o_key_held = 0.
- Frame 32'h00FF_45BA, then 5 repeat pulses spaced 5.5M cycles apart -> repeats 1–3 give no event; repeats 4 and 5 each give o_key_vld = 1 with o_key_rpt = 1; no release until 6M cycles after the last repeat.
- i_frame = 32'h00FF_4545 (cmd check fails) in IDLE -> o_err pulse, o_err_cnt = 1, no o_key_vld; the same while HELD -> o_err plus o_release, state IDLE.
- 300 bad frames -> o_err_cnt = 255 and holds; the 300th still pulses o_err.
- i_frame_vld and i_rpt_vld in the same cycle while HELD with cmd 8'h46 -> a single event with o_key_rpt = 0, o_cmd = 8'h46, repeat counter = 0; separately, a repeat on the timer-expiry cycle -> no release.
- P_ADDR_EN = 1, P_ADDR = 8'h10: frame 32'h20DF_45BA -> no output activity; frame 32'h10EF_45BA -> accepted with o_addr = 16'h0010. P_EXT_ADDR = 1: frame 32'h1234_45BA -> accepted with o_addr = 16'h1234. Orphan repeat in IDLE -> no activity.

Source files
------------

// File: rtl/ir_key_decoder.sv
// ir_key_decoder: post-processor for the NEC IR receiver.
// Validates each 32-bit frame and optionally filters it by address. Tracks the
// held key across repeat codes and emits single-cycle press, auto-repeat and
// release events. Integrity failures are counted in a saturating counter.
// Every output is registered, so each response lands one clk after the strobe.

module ir_key_decoder #(
    parameter int unsigned P_HOLD_TO   = 6000000,
    parameter int unsigned P_RPT_START = 4,
    parameter bit          P_ADDR_EN   = 1'b0,
    parameter logic [7:0]  P_ADDR      = 8'h00,
    parameter bit          P_EXT_ADDR  = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] i_frame,
    input  logic        i_frame_vld,
    input  logic        i_rpt_vld,
    output logic [15:0] o_addr,
    output logic [7:0]  o_cmd,
    output logic        o_key_vld,
    output logic        o_key_rpt,
    output logic        o_key_held,
    output logic        o_release,
    output logic        o_err,
    output logic [7:0]  o_err_cnt
);

    // Hold timer must represent P_HOLD_TO exactly; keep at least one bit.
    localparam int unsigned TW = (P_HOLD_TO > 0) ? $clog2(P_HOLD_TO + 1) : 1;
    localparam logic [TW-1:0] TIMER_LOAD = TW'(P_HOLD_TO);
    localparam logic [TW-1:0] TIMER_ONE  = TW'(1);
    localparam logic [7:0]    CNT_MAX    = 8'hFF;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HELD = 1'b1
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [TW-1:0] timer_q;
    logic [TW-1:0] timer_d;
    logic [7:0]    rpt_q;
    logic [7:0]    rpt_d;

    logic [15:0]   addr_d;
    logic [7:0]    cmd_d;
    logic          key_vld_d;
    logic          key_rpt_d;
    logic          held_d;
    logic          release_d;
    logic          err_d;
    logic [7:0]    err_cnt_d;

    // Frame qualification: integrity, address filter and repeat arbitration.
    logic          cmd_ok_c;
    logic          addr_ok_c;
    logic          good_c;
    logic          drop_c;
    logic          accept_c;
    logic          bad_c;
    logic          rpt_c;
    logic [15:0]   frame_addr_c;
    logic [7:0]    rpt_inc_c;

    // Combinational checks on the incoming frame and saturating repeat count.
    always_comb begin
        cmd_ok_c     = (i_frame[15:8] == ~i_frame[7:0]);
        addr_ok_c    = P_EXT_ADDR || (i_frame[31:24] == ~i_frame[23:16]);
        good_c       = cmd_ok_c && addr_ok_c;
        drop_c       = P_ADDR_EN && !P_EXT_ADDR && (i_frame[31:24] != P_ADDR);
        accept_c     = i_frame_vld && good_c && !drop_c;
        bad_c        = i_frame_vld && !good_c;
        // A frame in the same cycle always takes precedence over a repeat.
        rpt_c        = i_rpt_vld && !i_frame_vld;
        frame_addr_c = P_EXT_ADDR ? i_frame[31:16] : {8'h00, i_frame[31:24]};
        rpt_inc_c    = (rpt_q == CNT_MAX) ? rpt_q : rpt_q + 8'd1;
    end

    // Next-state and next-output logic for the key-hold state machine.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        rpt_d     = rpt_q;
        addr_d    = o_addr;
        cmd_d     = o_cmd;
        key_vld_d = 1'b0;
        key_rpt_d = 1'b0;
        held_d    = o_key_held;
        release_d = 1'b0;
        err_d     = 1'b0;
        err_cnt_d = o_err_cnt;

        // Integrity errors are reported in either state; counter saturates.
        if (bad_c) begin
            err_d = 1'b1;
            if (o_err_cnt != CNT_MAX) begin
                err_cnt_d = o_err_cnt + 8'd1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                // Orphan repeats and filtered frames leave IDLE untouched.
                if (accept_c) begin
                    addr_d    = frame_addr_c;
                    cmd_d     = i_frame[15:8];
                    key_vld_d = 1'b1;
                    held_d    = 1'b1;
                    timer_d   = TIMER_LOAD;
                    rpt_d     = 8'd0;
                    state_d   = ST_HELD;
                end
            end

            ST_HELD: begin
                if (accept_c) begin
                    // A fresh frame while held is a new press of (maybe) another key.
                    addr_d    = frame_addr_c;
                    cmd_d     = i_frame[15:8];
                    key_vld_d = 1'b1;
                    timer_d   = TIMER_LOAD;
                    rpt_d     = 8'd0;
                end else if (bad_c) begin
                    // A corrupted frame ends the hold.
                    held_d    = 1'b0;
                    release_d = 1'b1;
                    timer_d   = '0;
                    rpt_d     = 8'd0;
                    state_d   = ST_IDLE;
                end else if (rpt_c) begin
                    // Repeat keeps the key alive, even on the expiry cycle.
                    timer_d = TIMER_LOAD;
                    rpt_d   = rpt_inc_c;
                    if (32'(rpt_inc_c) >= P_RPT_START) begin
                        key_vld_d = 1'b1;
                        key_rpt_d = 1'b1;
                    end
                end else if (timer_q <= TIMER_ONE) begin
                    // Timer would reach zero this cycle: release the key.
                    held_d    = 1'b0;
                    release_d = 1'b1;
                    timer_d   = '0;
                    rpt_d     = 8'd0;
                    state_d   = ST_IDLE;
                end else begin
                    timer_d = timer_q - TIMER_ONE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, timer, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            timer_q    <= '0;
            rpt_q      <= 8'd0;
            o_addr     <= 16'd0;
            o_cmd      <= 8'd0;
            o_key_vld  <= 1'b0;
            o_key_rpt  <= 1'b0;
            o_key_held <= 1'b0;
            o_release  <= 1'b0;
            o_err      <= 1'b0;
            o_err_cnt  <= 8'd0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            rpt_q      <= rpt_d;
            o_addr     <= addr_d;
            o_cmd      <= cmd_d;
            o_key_vld  <= key_vld_d;
            o_key_rpt  <= key_rpt_d;
            o_key_held <= held_d;
            o_release  <= release_d;
            o_err      <= err_d;
            o_err_cnt  <= err_cnt_d;
        end
    end

endmodule
